// File: rtl/encoder_setting_bank.sv
// Multi-channel rotary-encoder setting bank.
// Synchronises and debounces a quadrature encoder. Each rising edge of the
// debounced A phase is a detent; B gives its direction. An accepted detent
// steps the setting chosen by sel, clamped to that channel's [MIN, MAX].
// Turning fast in one direction switches the step from 1 to FAST_STEP.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   en             - detents are discarded while low
//   encA, encB     - raw encoder phases, idle high
//   sel            - index of the setting to adjust
//   values         - registered settings, channel i at [i*VALUE_WIDTH +: VALUE_WIDTH]
//   changed        - one-cycle pulse when a setting actually changed
//   err            - sticky: a detent was dropped because sel was out of range
module encoder_setting_bank #(
    parameter int unsigned NUM_SETTINGS    = 2,
    parameter int unsigned SEL_WIDTH       = 1,
    parameter int unsigned VALUE_WIDTH     = 15,
    parameter logic [NUM_SETTINGS*VALUE_WIDTH-1:0] MIN_FLAT   = {15'd0, 15'd21},
    parameter logic [NUM_SETTINGS*VALUE_WIDTH-1:0] MAX_FLAT   = {15'd255, 15'd20971},
    parameter logic [NUM_SETTINGS*VALUE_WIDTH-1:0] RESET_FLAT = {15'd32, 15'd1048},
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FAST_STEP       = 16,
    parameter int unsigned FAST_WINDOW     = 50000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                en,
    input  logic                                encA,
    input  logic                                encB,
    input  logic [SEL_WIDTH-1:0]                sel,
    output logic [NUM_SETTINGS*VALUE_WIDTH-1:0] values,
    output logic                                changed,
    output logic                                err
);

    localparam int unsigned VW  = VALUE_WIDTH;
    localparam int unsigned CW  = VALUE_WIDTH + 1;
    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IW  = $clog2(FAST_WINDOW + 1);

    // Index 0 is phase A, index 1 is phase B.
    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [1:0]           r_db;
    logic [DCW-1:0]       r_cnt [2];
    logic                 r_db_a_prev;
    logic [IW-1:0]        r_interval;
    logic                 r_last_inc;
    logic [NUM_SETTINGS*VW-1:0] r_values;
    logic                 r_changed;
    logic                 r_err;

    logic                 w_detent;
    logic                 w_inc;
    logic                 w_sel_ok;
    logic                 w_accept;
    logic                 w_fast;
    logic [VW-1:0]        w_cur;
    logic [VW-1:0]        w_min;
    logic [VW-1:0]        w_max;
    logic [VW-1:0]        w_new;
    logic [CW-1:0]        w_step;
    logic [CW-1:0]        w_sum;
    logic [CW-1:0]        w_floor;

    // Two-flop synchroniser and per-phase debounce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_db    <= 2'b11;
            for (int p = 0; p < 2; p++) r_cnt[p] <= '0;
        end else begin
            r_sync1 <= {encB, encA};
            r_sync2 <= r_sync1;
            for (int p = 0; p < 2; p++) begin
                if (r_sync2[p] != r_db[p]) begin
                    if (r_cnt[p] == DCW'(DEBOUNCE_CYCLES - 1)) begin
                        r_db[p]  <= r_sync2[p];
                        r_cnt[p] <= '0;
                    end else begin
                        r_cnt[p] <= r_cnt[p] + DCW'(1);
                    end
                end else begin
                    r_cnt[p] <= '0;
                end
            end
        end
    end

    // Previous A level resets high so idle-high inputs never look like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_db_a_prev <= 1'b1;
        else       r_db_a_prev <= r_db[0];
    end

    assign w_detent = r_db[0] & ~r_db_a_prev;
    assign w_inc    = r_db[1];
    assign w_sel_ok = (32'(sel) < NUM_SETTINGS);
    assign w_accept = w_detent & en & w_sel_ok;
    assign w_fast   = (r_interval < IW'(FAST_WINDOW)) && (w_inc == r_last_inc);

    // Selected channel and its clamped next value, computed one bit wider.
    always_comb begin
        w_cur = '0;
        w_min = '0;
        w_max = '0;
        for (int i = 0; i < NUM_SETTINGS; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                w_cur = r_values[i*VW +: VW];
                w_min = MIN_FLAT[i*VW +: VW];
                w_max = MAX_FLAT[i*VW +: VW];
            end
        end
        w_step  = w_fast ? CW'(FAST_STEP) : CW'(1);
        w_sum   = CW'(w_cur) + w_step;
        w_floor = CW'(w_min) + w_step;
        if (w_inc) w_new = (w_sum > CW'(w_max)) ? w_max : VW'(w_sum);
        else       w_new = (CW'(w_cur) < w_floor) ? w_min : VW'(CW'(w_cur) - w_step);
    end

    // Saturating interval since the last accepted detent, and its direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_interval <= IW'(FAST_WINDOW);
            r_last_inc <= 1'b1;
        end else if (w_accept) begin
            r_interval <= '0;
            r_last_inc <= w_inc;
        end else if (r_interval != IW'(FAST_WINDOW)) begin
            r_interval <= r_interval + IW'(1);
        end
    end

    // Setting registers, change pulse and sticky range error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_values  <= RESET_FLAT;
            r_changed <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_accept) begin
                for (int i = 0; i < NUM_SETTINGS; i++) begin
                    if (sel == SEL_WIDTH'(i)) r_values[i*VW +: VW] <= w_new;
                end
                r_changed <= (w_new != w_cur);
            end
            if (w_detent && en && !w_sel_ok) r_err <= 1'b1;
        end
    end

    assign values  = r_values;
    assign changed = r_changed;
    assign err     = r_err;

endmodule

// File: tb/tb_encoder_setting_bank.sv
// Bench for encoder_setting_bank: a default-parameter instance for reset,
// latency and acceleration, and a 3-channel short-window instance driven by
// a vector table for clamping, enable, range error, glitch and reset cases.
module tb_encoder_setting_bank;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        en_a = 1'b1, enca_a = 1'b1, encb_a = 1'b1;
    logic [0:0]  sel_a = 1'b0;
    logic [29:0] values_a;
    logic        changed_a, err_a;

    logic        en_b = 1'b1, enca_b = 1'b1, encb_b = 1'b1;
    logic [1:0]  sel_b = 2'd0;
    logic [44:0] values_b;
    logic        changed_b, err_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    encoder_setting_bank dut_a (
        .clk(clk), .reset(reset), .en(en_a), .encA(enca_a), .encB(encb_a),
        .sel(sel_a), .values(values_a), .changed(changed_a), .err(err_a)
    );

    encoder_setting_bank #(
        .NUM_SETTINGS(3), .SEL_WIDTH(2), .VALUE_WIDTH(15),
        .MIN_FLAT({15'd5, 15'd0, 15'd21}),
        .MAX_FLAT({15'd40, 15'd255, 15'd20971}),
        .RESET_FLAT({15'd38, 15'd32, 15'd1048}),
        .DEBOUNCE_CYCLES(4), .FAST_STEP(16), .FAST_WINDOW(100)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .encA(enca_b), .encB(encb_b),
        .sel(sel_b), .values(values_b), .changed(changed_b), .err(err_b)
    );

    typedef struct {
        logic [1:0] sel;
        bit         b;
        bit         en;
        int         gap;
        int         ch;
        int         val;
        int         pulses;
        bit         err;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit chg(input int which);
        return (which == 0) ? changed_a : changed_b;
    endfunction

    function automatic int val_b(input int ch);
        return int'(values_b[ch*15 +: 15]);
    endfunction

    // One detent: A low long enough to debounce, then A high. Records the
    // edge offset (0 = first edge sampling A high) and count of pulses.
    task automatic detent(input int which, input logic [1:0] s, input bit b, input bit e,
                          input int gap, output int offs, output int np);
        @(negedge clk);
        if (which == 0) begin sel_a = s[0]; encb_a = b; en_a = e; enca_a = 1'b0; end
        else            begin sel_b = s;    encb_b = b; en_b = e; enca_b = 1'b0; end
        repeat (8) @(negedge clk);
        if (which == 0) enca_a = 1'b1;
        else            enca_b = 1'b1;
        offs = -1;
        np = 0;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk);
            #1;
            if (chg(which)) begin
                np++;
                if (offs < 0) offs = n;
            end
        end
        repeat (gap) @(posedge clk);
    endtask

    task automatic run_vec(input int i);
        int offs, np;
        detent(1, vecs[i].sel, vecs[i].b, vecs[i].en, vecs[i].gap, offs, np);
        check($sformatf("vec%0d value", i), val_b(vecs[i].ch), vecs[i].val);
        check($sformatf("vec%0d pulses", i), np, vecs[i].pulses);
        if (vecs[i].pulses == 1) check($sformatf("vec%0d latency", i), offs, 6);
        check($sformatf("vec%0d err", i), err_b, vecs[i].err);
    endtask

    initial begin
        int offs, np;

        //          sel   b     en    gap  ch  val   pulses err
        vecs[0]  = '{2'd0, 1'b1, 1'b1, 150, 0, 1049, 1, 1'b0};
        vecs[1]  = '{2'd0, 1'b1, 1'b1, 150, 0, 1050, 1, 1'b0};
        vecs[2]  = '{2'd0, 1'b1, 1'b1, 0,   0, 1051, 1, 1'b0};
        vecs[3]  = '{2'd1, 1'b0, 1'b1, 0,   1, 31,   1, 1'b0};
        vecs[4]  = '{2'd1, 1'b0, 1'b1, 0,   1, 15,   1, 1'b0};
        vecs[5]  = '{2'd1, 1'b0, 1'b1, 0,   1, 0,    1, 1'b0};
        vecs[6]  = '{2'd1, 1'b0, 1'b1, 0,   1, 0,    0, 1'b0};
        vecs[7]  = '{2'd1, 1'b0, 1'b1, 0,   1, 0,    0, 1'b0};
        vecs[8]  = '{2'd2, 1'b1, 1'b1, 0,   2, 39,   1, 1'b0};
        vecs[9]  = '{2'd2, 1'b0, 1'b1, 0,   2, 38,   1, 1'b0};
        vecs[10] = '{2'd2, 1'b1, 1'b1, 0,   2, 39,   1, 1'b0};
        vecs[11] = '{2'd2, 1'b0, 1'b1, 0,   2, 38,   1, 1'b0};
        for (int i = 12; i < 17; i++)
            vecs[i] = '{2'd2, 1'b1, 1'b0, 0, 2, 38, 0, 1'b0};
        vecs[17] = '{2'd2, 1'b1, 1'b1, 0,   2, 39,   1, 1'b0};
        vecs[18] = '{2'd2, 1'b1, 1'b1, 0,   2, 40,   1, 1'b0};
        vecs[19] = '{2'd2, 1'b1, 1'b1, 0,   2, 40,   0, 1'b0};
        vecs[20] = '{2'd3, 1'b1, 1'b1, 0,   2, 40,   0, 1'b1};
        vecs[21] = '{2'd2, 1'b1, 1'b1, 0,   2, 40,   0, 1'b1};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("a reset values", values_a, {15'd32, 15'd1048});
        check("a reset changed", changed_a, 0);
        check("a reset err", err_a, 0);
        check("b reset values", values_b, {15'd38, 15'd32, 15'd1048});

        // Idle high inputs never produce a detent.
        np = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (changed_a) np++;
        end
        check("a idle pulses", np, 0);
        check("a idle values", values_a, {15'd32, 15'd1048});

        // First detent steps by 1 after 6 edges; a quick second one by FAST_STEP.
        detent(0, 2'd0, 1'b1, 1'b1, 0, offs, np);
        check("a first value", values_a[14:0], 1049);
        check("a first pulses", np, 1);
        check("a first latency", offs, 6);
        detent(0, 2'd0, 1'b1, 1'b1, 0, offs, np);
        check("a fast value", values_a[14:0], 1065);
        check("a fast pulses", np, 1);
        check("a ch1 untouched", values_a[29:15], 32);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Three-cycle glitch on A is rejected by the debouncer.
        @(negedge clk);
        enca_b = 1'b0;
        repeat (8) @(negedge clk);
        enca_b = 1'b1;
        repeat (3) @(negedge clk);
        enca_b = 1'b0;
        np = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (changed_b) np++;
        end
        check("glitch pulses", np, 0);
        check("glitch values", values_b, {15'd38, 15'd0, 15'd1051});

        for (int i = 8; i < 22; i++) run_vec(i);
        check("b final values", values_b, {15'd40, 15'd0, 15'd1051});

        // Reset asserted mid-debounce discards the pending detent.
        @(negedge clk);
        enca_b = 1'b0;
        repeat (8) @(negedge clk);
        enca_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid reset values", values_b, {15'd38, 15'd32, 15'd1048});
        check("mid reset err", err_b, 0);
        check("mid reset changed", changed_b, 0);
        @(negedge clk);
        reset = 1'b0;
        np = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (changed_b) np++;
        end
        check("post reset pulses", np, 0);
        check("post reset values", values_b, {15'd38, 15'd32, 15'd1048});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
